// File: rtl/icache_assoc_pkg.sv
// Shared constants for the set-associative instruction cache.
// FSM encodings and a width helper used by the cache and its LRU.
package icache_assoc_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int LINE_BYTES_DEF = 16;
    localparam int NSETS_DEF      = 4;
    localparam int NWAYS_DEF      = 2;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = the cache, master = fetch stage plus memory.
interface icache_assoc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_W     = 128
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  flush;
    logic [31:0]           instr;
    logic                  instr_valid;
    logic                  stall;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ready;
    logic [LINE_W-1:0]     mem_data;

    modport slave (
        input  rd_en, addr, flush, mem_ready, mem_data,
        output instr, instr_valid, stall, mem_req, mem_addr
    );

    modport master (
        output rd_en, addr, flush, mem_ready, mem_data,
        input  instr, instr_valid, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_assoc_lru.sv
// True-LRU age tracker: age 0 is MRU, age NWAYS-1 is the victim.
// Invalid ways are preferred as victims, lowest index first.
module icache_assoc_lru
    import icache_assoc_pkg::*;
#(
    parameter int NSETS = 4,
    parameter int NWAYS = 2,
    localparam int IDX_W = log2c(NSETS),
    localparam int WAY_W = (NWAYS > 1) ? log2c(NWAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    input  logic [NWAYS-1:0] valid_vec,
    output logic [WAY_W-1:0] victim
);

    logic [WAY_W-1:0] age_q [NSETS][NWAYS];
    logic [WAY_W-1:0] age_d [NSETS][NWAYS];
    logic             found;

    always_comb begin
        age_d = age_q;
        if (touch) begin
            for (int w = 0; w < NWAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age_d[set_idx][w] = '0;
                else if (age_q[set_idx][w] < age_q[set_idx][touch_way])
                    age_d[set_idx][w] = age_q[set_idx][w] + 1'b1;
            end
        end
    end

    always_comb begin
        victim = '0;
        found  = 1'b0;
        for (int w = 0; w < NWAYS; w++) begin
            if (!valid_vec[w] && !found) begin
                victim = WAY_W'(w);
                found  = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < NWAYS; w++)
                if (age_q[set_idx][w] == WAY_W'(NWAYS - 1))
                    victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++)
                for (int w = 0; w < NWAYS; w++)
                    age_q[s][w] <= WAY_W'(w);
        end else begin
            age_q <= age_d;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with combinational hits
// and a registered single-line refill handshake to memory.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LINE_BYTES = LINE_BYTES_DEF,
    parameter int NSETS      = NSETS_DEF,
    parameter int NWAYS      = NWAYS_DEF
) (
    input  logic clk,
    input  logic reset,
    icache_assoc_if.slave bus
);

    localparam int OFF_W  = log2c(LINE_BYTES);
    localparam int IDX_W  = log2c(NSETS);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WAY_W  = (NWAYS > 1) ? log2c(NWAYS) : 1;

    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W+2:0]  bit_off;

    logic [LINE_W-1:0] data_mem [NSETS][NWAYS];
    logic [TAG_W-1:0]  tag_mem  [NSETS][NWAYS];
    logic [NWAYS-1:0]  valid_q  [NSETS];
    logic [NWAYS-1:0]  valid_d  [NSETS];

    logic [0:0]            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [TAG_W-1:0]      req_tag_q, req_tag_d;
    logic [IDX_W-1:0]      req_idx_q, req_idx_d;
    logic                  pend_q, pend_d;

    logic [NWAYS-1:0]  hit_vec;
    logic [WAY_W-1:0]  hit_way;
    logic              hit;
    logic [LINE_W-1:0] line_sel;
    logic              fill;
    logic              touch;
    logic [WAY_W-1:0]  touch_way;
    logic [IDX_W-1:0]  lru_set;
    logic [WAY_W-1:0]  victim;

    assign tag = bus.addr[ADDR_WIDTH-1 -: TAG_W];
    assign idx = bus.addr[OFF_W +: IDX_W];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < NWAYS; w++)
            hit_vec[w] = valid_q[idx][w] && (tag_mem[idx][w] == tag);
        for (int w = NWAYS - 1; w >= 0; w--)
            if (hit_vec[w]) hit_way = WAY_W'(w);
    end

    assign hit      = bus.rd_en && (state_q == IDLE) && (|hit_vec);
    assign line_sel = data_mem[idx][hit_way];

    // Byte offset scaled to bits with the two sub-word bits dropped.
    always_comb begin
        bit_off      = {bus.addr[OFF_W-1:0], 3'b000};
        bit_off[4:0] = '0;
    end

    assign bus.instr       = hit ? line_sel[bit_off +: 32] : '0;
    assign bus.instr_valid = hit;
    assign bus.stall       = reset &
                             ((state_q == REFILL) | (bus.rd_en & ~hit));
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

    assign fill    = (state_q == REFILL) && bus.mem_ready;
    assign lru_set = (state_q == REFILL) ? req_idx_q : idx;

    icache_assoc_lru #(
        .NSETS (NSETS),
        .NWAYS (NWAYS)
    ) u_lru (
        .clk       (clk),
        .rst_n     (reset),
        .set_idx   (lru_set),
        .touch     (touch),
        .touch_way (touch_way),
        .valid_vec (valid_q[lru_set]),
        .victim    (victim)
    );

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        req_tag_d  = req_tag_q;
        req_idx_d  = req_idx_q;
        pend_d     = pend_q;
        valid_d    = valid_q;
        touch      = 1'b0;
        touch_way  = hit_way;
        unique case (1'b1)
            (state_q == IDLE): begin
                touch = hit;
                if (bus.flush)
                    for (int s = 0; s < NSETS; s++) valid_d[s] = '0;
                if (bus.rd_en && !hit) begin
                    state_d    = REFILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {tag, idx, {OFF_W{1'b0}}};
                    req_tag_d  = tag;
                    req_idx_d  = idx;
                end
            end
            (state_q == REFILL): begin
                if (bus.flush) pend_d = 1'b1;
                if (bus.mem_ready) begin
                    touch     = 1'b1;
                    touch_way = victim;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    pend_d    = 1'b0;
                    // A flush seen during the refill also kills the new line.
                    if (pend_q || bus.flush)
                        for (int s = 0; s < NSETS; s++) valid_d[s] = '0;
                    else
                        valid_d[req_idx_q][victim] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            req_tag_q  <= '0;
            req_idx_q  <= '0;
            pend_q     <= 1'b0;
            for (int s = 0; s < NSETS; s++) valid_q[s] <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            req_tag_q  <= req_tag_d;
            req_idx_q  <= req_idx_d;
            pend_q     <= pend_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_mem[req_idx_q][victim] <= bus.mem_data;
            tag_mem[req_idx_q][victim]  <= req_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: recency-list cache model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_icache_assoc;

    logic clk = 1'b0;
    logic reset = 1'b0;

    icache_assoc_if #(.ADDR_WIDTH(32), .LINE_W(128)) bus ();

    icache_assoc #(
        .ADDR_WIDTH (32),
        .LINE_BYTES (16),
        .NSETS      (4),
        .NWAYS      (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    bit           m_valid [4][2];
    int unsigned  m_tag   [4][2];
    logic [127:0] m_data  [4][2];
    int           m_rec   [4][$];
    bit           m_refill, m_pend, m_req;
    logic [31:0]  m_addr;
    int unsigned  m_tagc;
    int           m_idxc;

    localparam logic [127:0] D50 =
        {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    localparam logic [127:0] D90 =
        {32'h93939393, 32'h92929292, 32'h91919191, 32'h90909090};
    localparam logic [127:0] DD0 =
        {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
    localparam logic [127:0] D10 =
        {32'h13131313, 32'h12121212, 32'h11110000, 32'h10101010};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(string nm, logic act, logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < 4; s++) begin
            m_rec[s].delete();
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_rec[s].push_back(w);
            end
        end
        m_refill = 1'b0;
        m_pend   = 1'b0;
        m_req    = 1'b0;
        m_addr   = '0;
    endfunction

    function automatic int m_lookup(logic [31:0] a);
        int s;
        s = int'(a[5:4]);
        for (int w = 0; w < 2; w++)
            if (m_valid[s][w] && m_tag[s][w] == int'(a[31:6])) return w;
        return -1;
    endfunction

    // Move a way to the most-recently-used end of its set's list.
    function automatic void m_touch(int s, int w);
        int pos;
        pos = -1;
        foreach (m_rec[s][i]) if (m_rec[s][i] == w) pos = i;
        if (pos >= 0) m_rec[s].delete(pos);
        m_rec[s].push_front(w);
    endfunction

    function automatic void m_clear();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    endfunction

    task automatic settle();
        int w;
        int s;
        logic e_iv;
        logic e_st;
        #4;
        if (!reset) begin
            m_reset();
            chk("rst_instr", bus.instr, 32'h0);
            e_iv = 1'b0;
            e_st = 1'b0;
            w = -1;
        end else if (m_refill) begin
            e_iv = 1'b0;
            e_st = 1'b1;
            w = -1;
        end else begin
            w = bus.rd_en ? m_lookup(bus.addr) : -1;
            e_iv = (w >= 0);
            e_st = bus.rd_en && (w < 0);
        end
        chkb("instr_valid", bus.instr_valid, e_iv);
        chkb("stall", bus.stall, e_st);
        chkb("mem_req", bus.mem_req, m_req);
        chk("mem_addr", bus.mem_addr, m_addr);
        if (w >= 0) begin
            s = int'(bus.addr[5:4]);
            chk("instr", bus.instr, m_data[s][w][bus.addr[3:2]*32 +: 32]);
        end
    endtask

    task automatic adv();
        int w;
        int v;
        if (!reset) begin
            m_reset();
        end else if (!m_refill) begin
            if (bus.rd_en) begin
                w = m_lookup(bus.addr);
                if (w >= 0) begin
                    m_touch(int'(bus.addr[5:4]), w);
                end else begin
                    m_refill = 1'b1;
                    m_req    = 1'b1;
                    m_addr   = {bus.addr[31:4], 4'h0};
                    m_tagc   = int'(bus.addr[31:6]);
                    m_idxc   = int'(bus.addr[5:4]);
                end
            end
            if (bus.flush) m_clear();
        end else begin
            if (bus.flush) m_pend = 1'b1;
            if (bus.mem_ready) begin
                v = -1;
                for (int i = 0; i < 2; i++)
                    if (!m_valid[m_idxc][i] && v < 0) v = i;
                if (v < 0) v = m_rec[m_idxc][$];
                m_data[m_idxc][v] = bus.mem_data;
                m_tag[m_idxc][v]  = m_tagc;
                m_touch(m_idxc, v);
                if (m_pend) m_clear();
                else m_valid[m_idxc][v] = 1'b1;
                m_refill = 1'b0;
                m_req    = 1'b0;
                m_pend   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic refill(int lat, logic [127:0] d);
        repeat (lat) cyc();
        bus.mem_ready = 1'b1;
        bus.mem_data  = d;
        cyc();
        bus.mem_ready = 1'b0;
    endtask

    task automatic fetch_miss(logic [31:0] a, int lat, logic [127:0] d);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        settle();
        chkb("miss_stall", bus.stall, 1'b1);
        adv();
        refill(lat, d);
    endtask

    logic [31:0] t2_exp [3];

    initial begin
        bus.rd_en     = 1'b0;
        bus.addr      = '0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = '0;
        m_reset();
        t2_exp = '{32'h11111111, 32'h22222222, 32'h33333333};

        @(posedge clk);
        #1;
        cyc();
        reset = 1'b1;

        // Cold miss on 0x50 with three cycles of memory latency.
        bus.rd_en = 1'b1;
        bus.addr  = 32'h50;
        settle();
        chkb("t1_stall", bus.stall, 1'b1);
        chkb("t1_iv", bus.instr_valid, 1'b0);
        adv();
        settle();
        chkb("t1_req", bus.mem_req, 1'b1);
        chk("t1_maddr", bus.mem_addr, 32'h50);
        adv();
        refill(2, D50);
        settle();
        chkb("t1_req_done", bus.mem_req, 1'b0);
        chkb("t1_hit", bus.instr_valid, 1'b1);
        chk("t1_instr", bus.instr, 32'h0);
        adv();

        for (int i = 0; i < 3; i++) begin
            bus.addr = 32'h54 + 32'(4 * i);
            settle();
            chk("t2_instr", bus.instr, t2_exp[i]);
            chkb("t2_iv", bus.instr_valid, 1'b1);
            chkb("t2_req", bus.mem_req, 1'b0);
            adv();
        end

        fetch_miss(32'h90, 2, D90);
        bus.addr = 32'h50;
        settle();
        chkb("t3_hit50", bus.instr_valid, 1'b1);
        adv();
        fetch_miss(32'hD0, 1, DD0);
        bus.addr = 32'h50;
        settle();
        chkb("t3_keep50", bus.instr_valid, 1'b1);
        chk("t3_instr50", bus.instr, 32'h0);
        adv();
        bus.addr = 32'h98;
        settle();
        chkb("t3_miss90", bus.stall, 1'b1);
        adv();
        settle();
        chk("t3_maddr90", bus.mem_addr, 32'h90);
        adv();
        refill(0, D90);
        settle();
        chk("t3_instr98", bus.instr, 32'h92929292);
        adv();

        bus.addr = 32'h10;
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        cyc();
        bus.mem_ready = 1'b1;
        bus.mem_data  = D10;
        cyc();
        bus.mem_ready = 1'b0;
        settle();
        chkb("t4_miss10", bus.stall, 1'b1);
        chkb("t4_iv10", bus.instr_valid, 1'b0);
        adv();
        refill(1, D10);
        bus.addr = 32'h50;
        settle();
        chkb("t4_miss50", bus.stall, 1'b1);
        adv();
        refill(0, D50);

        bus.addr = 32'hE0;
        cyc();
        settle();
        chkb("t5_req", bus.mem_req, 1'b1);
        #1 reset = 1'b0;
        #1 chkb("t5_async", bus.mem_req, 1'b0);
        adv();
        cyc();
        reset = 1'b1;
        bus.addr = 32'h50;
        settle();
        chkb("t5_miss50", bus.stall, 1'b1);
        adv();
        refill(2, D50);

        bus.rd_en     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_data  = DD0;
        cyc();
        bus.mem_ready = 1'b0;
        bus.rd_en = 1'b1;
        bus.addr  = 32'h50;
        settle();
        chkb("t6_iv", bus.instr_valid, 1'b1);
        chk("t6_instr", bus.instr, 32'h0);
        adv();
        bus.addr = 32'h5C;
        settle();
        chk("t6_instr5c", bus.instr, 32'h33333333);
        adv();

        for (int n = 0; n < 3000; n++) begin
            if (!m_refill) begin
                bus.rd_en = ($urandom_range(0, 4) != 0);
                bus.addr  = 32'($urandom_range(0, 255)) & 32'hFFFF_FFFC;
                if ($urandom_range(0, 7) == 0) bus.addr[31:28] = 4'hF;
                bus.flush     = ($urandom_range(0, 24) == 0);
                bus.mem_ready = ($urandom_range(0, 11) == 0);
            end else begin
                bus.flush     = ($urandom_range(0, 9) == 0);
                bus.mem_ready = ($urandom_range(0, 2) == 0);
            end
            bus.mem_data = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
